// File: rtl/se_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : se_vga_pkg
// Purpose  : Shared types and constants for the VRAM access scheduler.
//            - vram_state_e : scheduler state encoding
//            - ADDR_W / DATA_W / SEQ_W : bus widths
//            - FB_BYTES     : framebuffer size; the fetch address wraps here
//            - CPU_WIN_LAST : last pixel-group slot a CPU write may set up in
//                             while inside a fetch group
//            - FETCH_FIRST  : first slot of the VRAM fetch inside a group
// Revision : 1.0 - initial release
// ============================================================================
package se_vga_pkg;

  localparam int ADDR_W       = 15;
  localparam int DATA_W       = 8;
  localparam int SEQ_W        = 3;
  localparam int FB_BYTES     = 21888;
  localparam int CPU_WIN_LAST = 3;
  localparam int FETCH_FIRST  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VFETCH = 2'd1,
    CSETUP = 2'd2,
    CWRITE = 2'd3
  } vram_state_e;

  // Next framebuffer fetch address, wrapping at the end of the framebuffer.
  function automatic logic [ADDR_W-1:0] fetch_addr_next(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(FB_BYTES - 1)) begin
      return '0;
    end
    return a + 1'b1;
  endfunction

endpackage : se_vga_pkg
`default_nettype wire

// File: rtl/vram_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : vram_wbuf
// Purpose  : One-entry posted CPU write buffer. A request is captured (and
//            acknowledged on the following clock) whenever the buffer is
//            empty; the entry is released when the scheduler finishes its
//            CWRITE cycle. Requests arriving while full simply wait.
// Config   : compiled only when CPU_WRITE_BUFFER_EN is defined.
// Ports    : clk, nReset            - pixel clock (negedge), async reset
//            cpuReq/cpuAddr/cpuData - CPU write request
//            drainDone              - scheduler is in its CWRITE cycle
//            bufValid/bufAddr/bufData - buffered write toward the scheduler
//            cpuAck                 - one-clock acknowledge pulse
// Revision : 1.0 - initial release
// ============================================================================
`ifdef CPU_WRITE_BUFFER_EN
module vram_wbuf
  import se_vga_pkg::*;
(
  input  logic              clk,
  input  logic              nReset,
  input  logic              cpuReq,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuData,
  input  logic              drainDone,
  output logic              bufValid,
  output logic [ADDR_W-1:0] bufAddr,
  output logic [DATA_W-1:0] bufData,
  output logic              cpuAck
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              ack_q;
  logic              capture;

  // While full, cpuReq (including the one still high during the ack cycle)
  // is ignored, so a held request is only taken again after the drain.
  assign capture = cpuReq && !valid_q;

  always_ff @(negedge clk or negedge nReset) begin
    if (!nReset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= capture;
      if (capture) begin
        valid_q <= 1'b1;
        addr_q  <= cpuAddr;
        data_q  <= cpuData;
      end else if (drainDone) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bufValid = valid_q;
  assign bufAddr  = addr_q;
  assign bufData  = data_q;
  assign cpuAck   = ack_q;

endmodule : vram_wbuf
`endif
`default_nettype wire

// File: rtl/vram_sched.sv
`default_nettype none
// ============================================================================
// Module   : vram_sched
// Purpose  : Shares one VRAM port between the video fetch (one byte per
//            8-pixel group, slots 5..7) and CPU framebuffer writes
//            (CSETUP -> CWRITE). All state changes on the falling edge of
//            the pixel clock to line up with the video shifter.
// Config   : CPU_WRITE_BUFFER_EN - when defined, CPU writes are posted into
//            a one-entry buffer (vram_wbuf) and acknowledged immediately;
//            otherwise cpuAck follows completion of the CWRITE cycle.
// Ports    : clk, nReset          - pixel clock, async active-low reset
//            lineStart/frameStart - timing generator pulses
//            fetchActive          - video fetch window
//            cpuReq/cpuAddr/cpuData, cpuAck - CPU write handshake
//            seq                  - pixel-group slot number to the shifter
//            vramAddr/vramDout/nVramOE/nVramWE - VRAM port
// Revision : 1.0 - initial release
// ============================================================================
module vram_sched
  import se_vga_pkg::*;
(
  input  logic              clk,
  input  logic              nReset,
  input  logic              lineStart,
  input  logic              frameStart,
  input  logic              fetchActive,
  input  logic              cpuReq,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuData,
  output logic              cpuAck,
  output logic [SEQ_W-1:0]  seq,
  output logic [ADDR_W-1:0] vramAddr,
  output logic [DATA_W-1:0] vramDout,
  output logic              nVramOE,
  output logic              nVramWE
);

  vram_state_e       state_q, state_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              grp_q, grp_now;
  logic [ADDR_W-1:0] fetchAddr_q, fetchAddr_d;
  logic [ADDR_W-1:0] vramAddr_q, vramAddr_d;
  logic [DATA_W-1:0] vramDout_q, vramDout_d;
  logic              nVramOE_q, nVramWE_q;

  logic              wr_pending;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              fetch_due, cpu_win, slot_free, fetch_done;

  // Group membership is decided by fetchActive at slot 0; the registered copy
  // covers slots 1..7.
  assign grp_now   = (seq_q == '0) ? fetchActive : grp_q;
  assign seq_d     = lineStart ? '0 : seq_q + 1'b1;
  assign fetch_due = grp_now && (seq_q == SEQ_W'(FETCH_FIRST - 1)) && !lineStart;
  // The window is judged on the slot the CSETUP cycle would occupy, so the
  // following CWRITE ends no later than the slot before the fetch.
  assign cpu_win   = !grp_now || (seq_d <= SEQ_W'(CPU_WIN_LAST));

`ifdef CPU_WRITE_BUFFER_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  vram_wbuf u_wbuf (
    .clk       (clk),
    .nReset    (nReset),
    .cpuReq    (cpuReq),
    .cpuAddr   (cpuAddr),
    .cpuData   (cpuData),
    .drainDone (state_q == CWRITE),
    .bufValid  (buf_valid),
    .bufAddr   (buf_addr),
    .bufData   (buf_data),
    .cpuAck    (cpuAck)
  );

  assign wr_pending = buf_valid;
  assign wr_addr    = buf_addr;
  assign wr_data    = buf_data;
`else
  logic cpuAck_q;

  always_ff @(negedge clk or negedge nReset) begin
    if (!nReset) begin
      cpuAck_q <= 1'b0;
    end else begin
      cpuAck_q <= (state_q == CWRITE);
    end
  end

  // cpuReq seen during the ack cycle belongs to the write just finished.
  assign wr_pending = cpuReq && !cpuAck_q;
  assign wr_addr    = cpuAddr;
  assign wr_data    = cpuData;
  assign cpuAck     = cpuAck_q;
`endif

  always_comb begin
    state_d     = state_q;
    fetchAddr_d = fetchAddr_q;
    vramAddr_d  = vramAddr_q;
    vramDout_d  = vramDout_q;
    slot_free   = 1'b0;
    fetch_done  = 1'b0;

    case (state_q)
      IDLE: slot_free = 1'b1;
      VFETCH: begin
        if (lineStart) begin
          slot_free = 1'b1;           // aborted fetch: address not advanced
        end else if (seq_q == '1) begin
          slot_free  = 1'b1;
          fetch_done = 1'b1;
        end
      end
      CSETUP: state_d = CWRITE;
      CWRITE: slot_free = 1'b1;
      default: state_d = IDLE;
    endcase

    // Leaving a fetch is treated like IDLE, so a write waiting behind a fetch
    // starts in slot 0 of the next group. The fetch always wins the port.
    if (slot_free) begin
      if (fetch_due) begin
        state_d    = VFETCH;
        vramAddr_d = fetchAddr_q;
      end else if (wr_pending && cpu_win && (state_q != CWRITE)) begin
        state_d    = CSETUP;
        vramAddr_d = wr_addr;
        vramDout_d = wr_data;
      end else begin
        state_d = IDLE;
      end
    end

    if (frameStart) begin
      fetchAddr_d = '0;
    end else if (fetch_done) begin
      fetchAddr_d = fetch_addr_next(fetchAddr_q);
    end
  end

  always_ff @(negedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      grp_q       <= 1'b0;
      fetchAddr_q <= '0;
      vramAddr_q  <= '0;
      vramDout_q  <= '0;
      nVramOE_q   <= 1'b1;
      nVramWE_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      grp_q       <= grp_now;
      fetchAddr_q <= fetchAddr_d;
      vramAddr_q  <= vramAddr_d;
      vramDout_q  <= vramDout_d;
      // Strobes are registered from the next state so they are glitch-free
      // and still return high the instant reset is asserted.
      nVramOE_q   <= (state_d != VFETCH);
      nVramWE_q   <= (state_d != CWRITE);
    end
  end

  assign seq      = seq_q;
  assign vramAddr = vramAddr_q;
  assign vramDout = vramDout_q;
  assign nVramOE  = nVramOE_q;
  assign nVramWE  = nVramWE_q;

endmodule : vram_sched
`default_nettype wire
